// File: rtl/idc_pkg.sv
// Shared types and constants for the streaming ID checker (idc_gen, idc_mac).
// Symbol width, digit range, FSM state encoding and header tens/ones split.
package idc_pkg;

    localparam int SYM_W     = 6;
    localparam int DIGIT_MAX = 9;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    typedef struct packed {
        logic [2:0] tens;
        logic [3:0] ones;
    } head_split_t;

    function automatic head_split_t split_header(input logic [SYM_W-1:0] h);
        head_split_t r;
        r.tens = 3'(h / 6'd10);
        r.ones = 4'(h % 6'd10);
        return r;
    endfunction

endpackage

// File: rtl/idc_mac.sv
// Weighted accumulate step: next = (acc + sym * weight) mod MOD, purely combinational.
// Intermediate width covers the largest symbol (63) times the largest weight (15) plus acc.
module idc_mac import idc_pkg::*; #(
    parameter int MOD   = 10,
    parameter int ACC_W = 4
) (
    input  logic [ACC_W-1:0] i_acc,
    input  logic [SYM_W-1:0] i_sym,
    input  logic [3:0]       i_weight,
    output logic [ACC_W-1:0] o_acc
);

    localparam int PROD_W = 10;

    logic [PROD_W-1:0] w_prod;
    logic [PROD_W-1:0] w_sum;

    assign w_prod = PROD_W'(i_sym) * PROD_W'(i_weight);
    assign w_sum  = w_prod + PROD_W'(i_acc);
    assign o_acc  = ACC_W'(w_sum % PROD_W'(MOD));

endmodule

// File: rtl/idc_gen.sv
// Streaming ID checker: header + NUM_DIGITS digits, registered legal/illegal/error verdict.
// Optional out_check port (expected check digit) is built when IDC_CHECK_OUT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a header symbol; no gap counting
// COLLECT | consuming digits at position r_pos; gaps counted toward timeout
module idc_gen import idc_pkg::*; #(
    parameter int NUM_DIGITS = 9,
    parameter int MOD        = 10,
    parameter int HEAD_MIN   = 10,
    parameter int HEAD_MAX   = 35,
    parameter int TIMEOUT    = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] in_id,
    output logic             out_valid,
    output logic             out_legal_id,
    output logic             out_err
`ifdef IDC_CHECK_OUT_EN
    ,
    output logic [3:0]       out_check
`endif
);

    localparam int ACC_W  = (MOD > 1) ? $clog2(MOD) : 1;
    localparam int POS_W  = $clog2(NUM_DIGITS + 1);
    localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t             r_state, w_state_nxt;
    logic [ACC_W-1:0]   r_acc, w_acc_nxt;
    logic [POS_W-1:0]   r_pos, w_pos_nxt;
    logic               r_err, w_err_nxt;
    logic [IDLE_W-1:0]  r_idle, w_idle_nxt;
    logic               r_out_valid, w_out_valid_nxt;
    logic               r_out_legal, w_out_legal_nxt;
    logic               r_out_err, w_out_err_nxt;

    logic [ACC_W-1:0]   w_mac_acc_in, w_mac_acc_out;
    logic [SYM_W-1:0]   w_mac_sym;
    logic [3:0]         w_mac_weight;
    head_split_t        w_head;
    logic               w_head_bad, w_digit_bad, w_err_acc, w_last, w_timeout;

    assign w_head      = split_header(in_id);
    assign w_head_bad  = (int'(in_id) < HEAD_MIN) || (int'(in_id) > HEAD_MAX);
    assign w_digit_bad = int'(in_id) > DIGIT_MAX;
    assign w_err_acc   = r_err | w_digit_bad;
    assign w_last      = (int'(r_pos) == NUM_DIGITS);
    assign w_timeout   = (TIMEOUT > 0) && ((int'(r_idle) + 1) >= TIMEOUT);

    // Header seeds the accumulator as tens*1 + ones*NUM_DIGITS through the same MAC.
    always_comb begin
        w_mac_acc_in = r_acc;
        w_mac_sym    = in_id;
        w_mac_weight = w_last ? 4'd1 : 4'(NUM_DIGITS - int'(r_pos));
        if (r_state == IDLE) begin
            w_mac_acc_in = ACC_W'(int'(w_head.tens) % MOD);
            w_mac_sym    = SYM_W'(w_head.ones);
            w_mac_weight = 4'(NUM_DIGITS);
        end
    end

    idc_mac #(
        .MOD   (MOD),
        .ACC_W (ACC_W)
    ) u_mac (
        .i_acc    (w_mac_acc_in),
        .i_sym    (w_mac_sym),
        .i_weight (w_mac_weight),
        .o_acc    (w_mac_acc_out)
    );

`ifdef IDC_CHECK_OUT_EN
    logic [3:0] r_out_check, w_out_check_nxt;
    assign out_check = r_out_check;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_pos_nxt       = r_pos;
        w_err_nxt       = r_err;
        w_idle_nxt      = r_idle;
        w_out_valid_nxt = 1'b0;
        w_out_legal_nxt = 1'b0;
        w_out_err_nxt   = 1'b0;
`ifdef IDC_CHECK_OUT_EN
        w_out_check_nxt = 4'd0;
`endif
        case (r_state)
            IDLE: begin
                w_idle_nxt = '0;
                if (in_valid) begin
                    w_acc_nxt   = w_mac_acc_out;
                    w_pos_nxt   = POS_W'(1);
                    w_err_nxt   = w_head_bad;
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    w_idle_nxt = '0;
                    if (w_last) begin
                        w_out_valid_nxt = 1'b1;
                        w_out_legal_nxt = (w_mac_acc_out == '0) && !w_err_acc;
                        w_out_err_nxt   = w_err_acc;
`ifdef IDC_CHECK_OUT_EN
                        w_out_check_nxt = w_err_acc ? 4'd0 : 4'((MOD - int'(r_acc)) % MOD);
`endif
                        w_state_nxt = IDLE;
                        w_acc_nxt   = '0;
                        w_pos_nxt   = '0;
                        w_err_nxt   = 1'b0;
                    end else begin
                        w_acc_nxt = w_mac_acc_out;
                        w_pos_nxt = r_pos + POS_W'(1);
                        w_err_nxt = w_err_acc;
                    end
                end else if (w_timeout) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_err_nxt   = 1'b1;
                    w_state_nxt     = IDLE;
                    w_acc_nxt       = '0;
                    w_pos_nxt       = '0;
                    w_err_nxt       = 1'b0;
                    w_idle_nxt      = '0;
                end else begin
                    w_idle_nxt = r_idle + IDLE_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_pos       <= '0;
            r_err       <= 1'b0;
            r_idle      <= '0;
            r_out_valid <= 1'b0;
            r_out_legal <= 1'b0;
            r_out_err   <= 1'b0;
`ifdef IDC_CHECK_OUT_EN
            r_out_check <= 4'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_pos       <= w_pos_nxt;
            r_err       <= w_err_nxt;
            r_idle      <= w_idle_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_legal <= w_out_legal_nxt;
            r_out_err   <= w_out_err_nxt;
`ifdef IDC_CHECK_OUT_EN
            r_out_check <= w_out_check_nxt;
`endif
        end
    end

    assign out_valid    = r_out_valid;
    assign out_legal_id = r_out_legal;
    assign out_err      = r_out_err;

endmodule
